// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: one shared FP_Multiplier serving NREQ valid/ready requesters.
// Grants are round-robin and one transaction is in flight at a time. The
// product is registered and held, tagged with the winning requester's index,
// until the downstream side accepts it.
// Build option: define FP_MUL_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (lowest index always wins, no rotating pointer).
// Also holds FP_Multiplier: combinational IEEE-754 multiplier, round to
// nearest even, subnormals flushed to zero.

module FP_Multiplier #(
    parameter int N  = 32,
    parameter int EW = (N == 64) ? 11 : ((N == 16) ? 5 : 8)
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Result
);
    localparam int MW   = N - 1 - EW;
    localparam int BIAS = (2 ** (EW - 1)) - 1;
    localparam int EMAX = (2 ** EW) - 1;

    logic          sign;
    logic [EW-1:0] ea, eb;
    logic [MW:0]   ma, mb;
    logic [2*MW+1:0] prod;
    logic [MW-1:0] mant;
    logic [MW:0]   mant_r;
    logic          guard, sticky, rnd;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    int            e;

    // Unpack, multiply significands, normalise one place, round, then
    // override with the special-value results.
    always_comb begin
        sign   = A[N-1] ^ B[N-1];
        ea     = A[N-2:MW];
        eb     = B[N-2:MW];
        ma     = {1'b1, A[MW-1:0]};
        mb     = {1'b1, B[MW-1:0]};
        a_nan  = (ea == {EW{1'b1}}) && (A[MW-1:0] != '0);
        b_nan  = (eb == {EW{1'b1}}) && (B[MW-1:0] != '0);
        a_inf  = (ea == {EW{1'b1}}) && (A[MW-1:0] == '0);
        b_inf  = (eb == {EW{1'b1}}) && (B[MW-1:0] == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        prod   = ma * mb;
        // Product of two [1,2) significands lies in [1,4): the top bit picks the shift.
        mant   = prod[2*MW+1] ? prod[2*MW:MW+1] : prod[2*MW-1:MW];
        guard  = prod[2*MW+1] ? prod[MW] : prod[MW-1];
        sticky = prod[2*MW+1] ? (|prod[MW-1:0]) : (|prod[MW-2:0]);
        rnd    = guard && (sticky || mant[0]);
        mant_r = {1'b0, mant} + {{MW{1'b0}}, rnd};
        e      = int'(ea) + int'(eb) - BIAS + (prod[2*MW+1] ? 1 : 0) + (mant_r[MW] ? 1 : 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            Result = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        else if (a_inf || b_inf)
            Result = {sign, {EW{1'b1}}, {MW{1'b0}}};
        else if (a_zero || b_zero || e <= 0)
            Result = {sign, {(N-1){1'b0}}};
        else if (e >= EMAX)
            Result = {sign, {EW{1'b1}}, {MW{1'b0}}};
        else
            Result = {sign, EW'(e), mant_r[MW-1:0]};
    end
endmodule

module fp_mul_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_result,
    output logic [IDW-1:0]      out_id
);
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    op_a, op_b, mul_res;
    logic [IDW-1:0]  id_q;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_id, cand;
    logic            xfer;

    FP_Multiplier #(.N(N)) u_mul (
        .A      (op_a),
        .B      (op_b),
        .Result (mul_res)
    );

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest valid index wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'(k);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end
`else
    logic [IDW-1:0] ptr;

    // Round-robin: search from ptr+1 upward, wrapping; first valid wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    // Pointer moves only on an accepted transfer; reset gives requester 0 first turn.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= IDW'(NREQ - 1);
        else if (xfer)
            ptr <= gnt_id;
    end
`endif

    assign xfer      = (state == IDLE) && gnt_any;
    assign out_valid = (state == HOLD);

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and per-requester accept.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    req_ready[gnt_id] = 1'b1;
                    state_nxt         = MUL;
                end
            end
            MUL:     state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on grant; product and tag captured after one settling cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            id_q       <= '0;
            out_result <= '0;
            out_id     <= '0;
        end else begin
            if (xfer) begin
                op_a <= req_a[gnt_id*N +: N];
                op_b <= req_b[gnt_id*N +: N];
                id_q <= gnt_id;
            end
            if (state == MUL) begin
                out_result <= mul_res;
                out_id     <= id_q;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter (NREQ=4, N=32).
module tb_fp_mul_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*N-1:0]   req_a, req_b;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_result;
    logic [IDW-1:0]      out_id;

    int checks = 0;
    int errors = 0;

    fp_mul_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_id     (out_id)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic test_reset();
        req_a = '0;
        req_b = '0;
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
        checks++;
        if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id got %0d want 0", out_id); end
        // Idle with no requests and out_ready high: nothing happens.
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cyc %0d got ready=%b valid=%b want 0000/0", c, req_ready, out_valid);
            end
            tick();
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        set_req(0, 32'h3FC00000, 32'h3FC00000);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL single_mul got valid=%b ready=%b want 0/0000", out_valid, req_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h40100000 || out_id !== 2'd0) begin
            errors++; $display("FAIL single_out got v=%b r=%h id=%0d want 1/40100000/0", out_valid, out_result, out_id);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got valid=%b want 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b1;
        set_req(1, 32'h40000000, 32'h40400000);
        set_req(2, 32'hBF000000, 32'h40800000);
        req_valid = 4'b0110;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL simul_first_grant got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL simul_mul_ready got %b want 0000", req_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h40C00000 || out_id !== 2'd1) begin
            errors++; $display("FAIL simul_out1 got v=%b r=%h id=%0d want 1/40C00000/1", out_valid, out_result, out_id);
        end
        tick();
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL simul_second_grant got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'hC0000000 || out_id !== 2'd2) begin
            errors++; $display("FAIL simul_out2 got v=%b r=%h id=%0d want 1/C0000000/2", out_valid, out_result, out_id);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [31:0] bval [NREQ];
        logic [3:0]  exp_rdy;
        int          w;
        bval[0] = 32'h3F800000;
        bval[1] = 32'h40000000;
        bval[2] = 32'h40400000;
        bval[3] = 32'h40800000;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h3F800000, bval[i]);
        req_valid = 4'b1111;
        for (int g = 0; g < 8; g++) begin
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = g % NREQ;
`endif
            exp_rdy = 4'b0001 << w;
            #1;
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant %0d got %b want %b", g, req_ready, exp_rdy); end
            tick();
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_id !== IDW'(w) || out_result !== bval[w]) begin
                errors++; $display("FAIL fair_out %0d got v=%b id=%0d r=%h want 1/%0d/%h", g, out_valid, out_id, out_result, w, bval[w]);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_req(0, 32'h40000000, 32'h40000000);
        set_req(3, 32'h3F800000, 32'hC0400000);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b1000;
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== 32'h40800000 || out_id !== 2'd0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b r=%h id=%0d rdy=%b want 1/40800000/0/0000",
                         c, out_valid, out_result, out_id, req_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_release got v=%b rdy=%b want 1/0000", out_valid, req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant3 got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'hC0400000 || out_id !== 2'd3) begin
            errors++; $display("FAIL bp_out3 got v=%b r=%h id=%0d want 1/C0400000/3", out_valid, out_result, out_id);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        // Move the pointer away from its reset value with a grant to requester 2.
        set_req(2, 32'h40000000, 32'h40000000);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        // Requester 1 wins next, then reset lands while it is in MUL.
        set_req(1, 32'h40400000, 32'h40400000);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid0 got %b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid1 got %b want 0", out_valid); end
        // With the pointer back at 3, requester 1 beats requester 3.
        set_req(3, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_grant got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b1000;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h41100000 || out_id !== 2'd1) begin
            errors++; $display("FAIL rstmid_out got v=%b r=%h id=%0d want 1/41100000/1", out_valid, out_result, out_id);
        end
        tick();
        tick();
        req_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h3F800000 || out_id !== 2'd3) begin
            errors++; $display("FAIL rstmid_out3 got v=%b r=%h id=%0d want 1/3F800000/3", out_valid, out_result, out_id);
        end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Shares one combinational `FP_Multiplier` instance between `NREQ` requesters. Each requester presents an operand pair under a valid/ready handshake. Grants go round-robin, one transaction at a time. The product is registered and returned on a single output channel, tagged with the winning requester's index and subject to downstream backpressure. The block sits between the issue logic and the FP datapath, alongside `float_adder_subtractor`.

## Interface
- `N`, 32: operand/result width; passed to `FP_Multiplier #(.N(N))`.
- `NREQ`, 4: number of requesters, at least 2.
- `IDW`, `$clog2(NREQ)`: width of the requester index.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit high.
- `req_a`  in  NREQ*N  packed A operands; requester i occupies `[i*N +: N]`.
- `req_b`  in  NREQ*N  packed B operands, same packing as `req_a`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accept.
- `out_result`  out  N  registered product.
- `out_id`  out  IDW  index of the requester that produced `out_result`.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - MUL: operands are registered and the multiplier is settling.
  - HOLD: result is registered and waiting for `out_ready`.
- IDLE:
  - `req_ready[i]` = 1 only for the arbitration winner i.
  - If any `req_valid` is set, a transfer occurs in that cycle.
  - On transfer: latch `req_a`/`req_b` slice i into `op_a`/`op_b`, latch i into `id_q`, update the pointer to i, go to MUL.
- MUL:
  - `FP_Multiplier` is driven by `op_a`/`op_b`.
  - At the clock edge, its `Result` is latched into `out_result` and the FSM goes to HOLD.
- HOLD:
  - `out_valid` = 1.
  - `out_result` and `out_id` are held stable.
  - When `out_ready` = 1, the output transfers and the FSM returns to IDLE.
- `req_ready` is 0 in MUL and HOLD.
- Round-robin arbitration:
  - Search order starts at `ptr+1` and wraps modulo `NREQ`.
  - The first asserted `req_valid` wins.
  - `ptr` updates only on an accepted transfer.
- Requester rules:
  - `req_ready` depends combinationally on `req_valid` and the FSM state.
  - Requesters must not derive `req_valid` from `req_ready`.
  - Once `req_valid` is asserted, the requester holds it and its operands stable until accepted.
- Arithmetic:
  - Bit-exact pass-through of `FP_Multiplier` output.
  - The block performs no rounding, flag or special-value handling of its own.
- Boundary conditions:
  - `req_valid` all zero in IDLE: stay in IDLE, all `req_ready` = 0, `ptr` unchanged.
  - New requests arriving while in MUL or HOLD wait; no request is dropped.
  - `out_ready` high outside HOLD has no effect.
  - `rst` mid-transaction discards the in-flight operation. The next cycle shows IDLE, `out_valid` = 0, `ptr` = NREQ-1.

## Timing
- Reset values:
  - FSM in IDLE.
  - `out_valid` = 0, `out_result` = 0, `out_id` = 0.
  - `ptr` = NREQ-1, so requester 0 has first priority.
  - `req_ready` follows the IDLE arbitration from the first post-reset cycle.
- Latency: transfer at cycle t, then MUL at t+1, then `out_valid` = 1 at t+2.
- Fastest output: with `out_ready` held high, `out_valid` is high for exactly one cycle.
- Next acceptance: the next request can be accepted at t+3.
- Throughput: one operation per 3 cycles at best.
- Backpressure: HOLD lasts as long as `out_ready` = 0; there is no limit.
- Critical path: the multiplier runs register-to-register, `op_*` to `out_result`, over one full cycle.

## Configuration
- `FP_MUL_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins every time. `ptr` is not implemented; `out_id` is unaffected.
  - Undefined (default): round-robin as described above.

## Test plan
- Single request:
  - Stimulus: requester 0 sends A=0x3FC00000, B=0x3FC00000, with `out_ready`=1.
  - Response: `req_ready[0]` high that cycle; `out_valid` 2 cycles later with `out_result`=0x40100000 and `out_id`=0.
- Simultaneous requests:
  - Stimulus: requesters 1 and 2 valid out of reset. Requester 1 sends 0x40000000 × 0x40400000; requester 2 sends 0xBF000000 × 0x40800000.
  - Response: requester 1 is granted first and returns 0x40C00000, id 1. Requester 2 is granted 3 cycles later and returns 0xC0000000, id 2.
- Fairness:
  - Stimulus: all 4 requesters held valid for 8 grants.
  - Response: grant order is 0,1,2,3,0,1,2,3.
  - With `FP_MUL_ARB_FIXED_PRIO_EN` defined, the order is 0,0,0,...
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles while requester 3 is also valid.
  - Response: `out_result` and `out_id` stay stable and all `req_ready`=0. Requester 3 is accepted the cycle after `out_ready` rises.
- Reset mid-transaction:
  - Stimulus: assert `rst` for 1 cycle during MUL.
  - Response: no `out_valid`; `ptr` returns to NREQ-1. A re-issued request completes normally with the correct product.
